// File: rtl/wide_reg_bank_pkg.sv
// Shared constants and address helpers for the wide register bank.
package wide_reg_bank_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [31:0] u32_t;

    typedef struct packed {
        u32_t idx;
        u32_t off;
    } split_t;

    function automatic int addr_width(int nregs, int words);
        return $clog2(nregs * words) + 2;
    endfunction

    function automatic split_t split_addr(u32_t waddr, int words);
        split_t s;
        s.idx = waddr / u32_t'(words);
        s.off = waddr % u32_t'(words);
        return s;
    endfunction

endpackage

// File: rtl/wide_reg_slice.sv
// One wide register: write shadow, storage/pulse behaviour, read shadow, strobe.
// Shadow staging exists only with WIDE_REG_BANK_ATOMIC_EN defined.
module wide_reg_slice
    import wide_reg_bank_pkg::*;
#(
    parameter int WORDS = 2,
    parameter bit PULSE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  u32_t                    wr_off_i,
    input  logic [WORD_W-1:0]       wr_data_i,
    input  logic                    rd_en_i,
    input  u32_t                    rd_off_i,
    output logic [WORD_W-1:0]       rd_word_o,
    output logic [WORDS*WORD_W-1:0] val_o,
    output logic                    strobe_o
);

    typedef logic [WORDS-1:0][WORD_W-1:0] wide_t;

    wide_t val_q, val_d;
    logic  strobe_q, strobe_d;

`ifdef WIDE_REG_BANK_ATOMIC_EN
    wide_t wsh_q, wsh_d, rsh_q, rsh_d;

    always_comb begin
        wsh_d = wsh_q;
        for (int k = 0; k < WORDS; k++) begin
            if (wr_en_i && wr_off_i == u32_t'(k)) wsh_d[WORDS-1-k] = wr_data_i;
        end
        strobe_d = wr_en_i && (wr_off_i == u32_t'(WORDS-1));
        val_d    = PULSE ? '0 : val_q;
        if (strobe_d) val_d = wsh_d;
        rsh_d = rsh_q;
        if (rd_en_i && rd_off_i == '0 && !PULSE) rsh_d = val_q;
    end

    // Offset 0 reads live and snapshots; later offsets read the snapshot.
    always_comb begin
        rd_word_o = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (rd_off_i == u32_t'(k)) rd_word_o = rsh_q[WORDS-1-k];
        end
        if (rd_off_i == '0) rd_word_o = val_q[WORDS-1];
        if (PULSE) rd_word_o = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wsh_q <= '0;
            rsh_q <= '0;
        end else begin
            wsh_q <= wsh_d;
            rsh_q <= rsh_d;
        end
    end
`else
    logic rd_en_unused;
    assign rd_en_unused = rd_en_i;

    always_comb begin
        strobe_d = wr_en_i;
        val_d    = PULSE ? '0 : val_q;
        for (int k = 0; k < WORDS; k++) begin
            if (wr_en_i && wr_off_i == u32_t'(k)) val_d[WORDS-1-k] = wr_data_i;
        end
    end

    always_comb begin
        rd_word_o = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (rd_off_i == u32_t'(k)) rd_word_o = val_q[WORDS-1-k];
        end
        if (PULSE) rd_word_o = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            val_q    <= val_d;
            strobe_q <= strobe_d;
        end
    end

    assign val_o    = val_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/wide_reg_bank.sv
// Bank of wide control registers on a single-strobe bus: pipeline, decode, read mux.
// Define WIDE_REG_BANK_ATOMIC_EN for shadowed atomic multi-word access.
module wide_reg_bank
    import wide_reg_bank_pkg::*;
#(
    parameter int               NREGS      = 4,
    parameter int               WORDS      = 2,
    parameter logic [NREGS-1:0] PULSE_MASK = '0,
    localparam int              AW         = addr_width(NREGS, WORDS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AW-1:2]                 vme_addr,
    input  logic [WORD_W-1:0]             vme_wr_data,
    input  logic                          vme_wr_mem,
    input  logic                          vme_rd_mem,
    output logic [WORD_W-1:0]             vme_rd_data,
    output logic                          vme_wr_done,
    output logic                          vme_rd_done,
    output logic [NREGS*WORDS*WORD_W-1:0] regs_o,
    output logic [NREGS-1:0]              wr_strobe_o
);

    logic                    wr_vld_q;
    logic [AW-1:2]           wr_addr_q;
    logic [WORD_W-1:0]       wr_data_q;
    logic                    wr_done_q;
    logic                    rd_done_q;
    logic [WORD_W-1:0]       rd_data_q, rd_data_d;

    split_t                        wsp, rsp;
    logic [NREGS-1:0]              wr_sel, rd_sel;
    logic [NREGS-1:0][WORD_W-1:0]  rd_words;
    logic [WORD_W-1:0]             rd_mux;

    // Unmatched (out-of-range) indices select nothing and read as zero.
    always_comb begin
        wsp    = split_addr(u32_t'(wr_addr_q), WORDS);
        rsp    = split_addr(u32_t'(vme_addr), WORDS);
        rd_mux = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_sel[i] = wr_vld_q && (wsp.idx == u32_t'(i));
            rd_sel[i] = vme_rd_mem && (rsp.idx == u32_t'(i));
            if (rsp.idx == u32_t'(i)) rd_mux = rd_words[i];
        end
        rd_data_d = vme_rd_mem ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_vld_q  <= vme_wr_mem;
            wr_addr_q <= vme_addr;
            wr_data_q <= vme_wr_data;
            wr_done_q <= wr_vld_q;
            rd_done_q <= vme_rd_mem;
            rd_data_q <= rd_data_d;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        wide_reg_slice #(
            .WORDS (WORDS),
            .PULSE (PULSE_MASK[i])
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (wr_sel[i]),
            .wr_off_i  (wsp.off),
            .wr_data_i (wr_data_q),
            .rd_en_i   (rd_sel[i]),
            .rd_off_i  (rsp.off),
            .rd_word_o (rd_words[i]),
            .val_o     (regs_o[i*WORDS*WORD_W +: WORDS*WORD_W]),
            .strobe_o  (wr_strobe_o[i])
        );
    end

    assign vme_wr_done = wr_done_q;
    assign vme_rd_done = rd_done_q;
    assign vme_rd_data = rd_data_q;

endmodule

// File: tb/tb_wide_reg_bank.sv
// Randomised and directed bench for wide_reg_bank against a behavioural model.
module tb_wide_reg_bank;

    localparam int NR  = 3;
    localparam int NW  = 2;
    localparam int AWD = 5;
    localparam int RW  = NW * 32;
    localparam int BW  = NR * RW;
    localparam logic [NR-1:0] PM = 3'b001;
`ifdef WIDE_REG_BANK_ATOMIC_EN
    localparam bit ATOM = 1'b1;
`else
    localparam bit ATOM = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AWD-1:2]  vme_addr;
    logic [31:0]     vme_wr_data;
    logic            vme_wr_mem;
    logic            vme_rd_mem;
    logic [31:0]     vme_rd_data;
    logic            vme_wr_done;
    logic            vme_rd_done;
    logic [BW-1:0]   regs_o;
    logic [NR-1:0]   wr_strobe_o;

    wide_reg_bank #(
        .NREGS      (NR),
        .WORDS      (NW),
        .PULSE_MASK (PM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vme_addr    (vme_addr),
        .vme_wr_data (vme_wr_data),
        .vme_wr_mem  (vme_wr_mem),
        .vme_rd_mem  (vme_rd_mem),
        .vme_rd_data (vme_rd_data),
        .vme_wr_done (vme_wr_done),
        .vme_rd_done (vme_rd_done),
        .regs_o      (regs_o),
        .wr_strobe_o (wr_strobe_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [BW-1:0] got,
                         input logic [BW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Model: registers as whole values, word k counted from the MS end.
    logic [RW-1:0] m_val [NR];
    logic [RW-1:0] m_wsh [NR];
    logic [RW-1:0] m_rsh [NR];
    logic          p_v;
    int            p_a;
    logic [31:0]   p_d;
    logic [BW-1:0] e_regs;
    logic [NR-1:0] e_stb;
    logic          e_wd, e_rd;
    logic [31:0]   e_rdat;

    function automatic logic [31:0] getw(logic [RW-1:0] v, int o);
        return 32'(v >> (32 * (NW - 1 - o)));
    endfunction

    function automatic logic [RW-1:0] setw(logic [RW-1:0] v, int o, logic [31:0] d);
        logic [RW-1:0] m;
        int sh;
        sh = 32 * (NW - 1 - o);
        m  = RW'(32'hFFFF_FFFF) << sh;
        return (v & ~m) | (RW'(d) << sh);
    endfunction

    task automatic m_step(input logic r, input logic w, input int a, input logic [31:0] d);
        logic [RW-1:0] shw [NR];
        int ri, oi;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                m_val[i] = '0;
                m_wsh[i] = '0;
                m_rsh[i] = '0;
            end
            p_v = 1'b0; e_regs = '0; e_stb = '0;
            e_wd = 1'b0; e_rd = 1'b0; e_rdat = '0;
            return;
        end
        e_rd = r;
        if (r) begin
            ri = a / NW;
            oi = a % NW;
            if (ri >= NR || PM[ri]) e_rdat = '0;
            else if (!ATOM) e_rdat = getw(m_val[ri], oi);
            else if (oi == 0) begin
                e_rdat    = getw(m_val[ri], 0);
                m_rsh[ri] = m_val[ri];
            end else e_rdat = getw(m_rsh[ri], oi);
        end
        e_wd  = p_v;
        e_stb = '0;
        for (int i = 0; i < NR; i++) shw[i] = '0;
        if (p_v && (p_a / NW) < NR) begin
            ri = p_a / NW;
            oi = p_a % NW;
            if (ATOM) begin
                m_wsh[ri] = setw(m_wsh[ri], oi, p_d);
                if (oi == NW - 1) begin
                    m_val[ri] = m_wsh[ri];
                    e_stb[ri] = 1'b1;
                    shw[ri]   = m_val[ri];
                end
            end else begin
                m_val[ri] = setw(m_val[ri], oi, p_d);
                e_stb[ri] = 1'b1;
                shw[ri]   = setw('0, oi, p_d);
            end
        end
        for (int i = 0; i < NR; i++) e_regs[i*RW +: RW] = PM[i] ? shw[i] : m_val[i];
        p_v = w;
        p_a = a;
        p_d = d;
    endtask

    task automatic cyc(input logic r, input logic w, input int a, input logic [31:0] d);
        vme_rd_mem  = r;
        vme_wr_mem  = w;
        vme_addr    = a[AWD-3:0];
        vme_wr_data = d;
        m_step(r, w, a, d);
        @(posedge clk);
        #1;
        check("regs", regs_o, e_regs);
        check("strobe", BW'(wr_strobe_o), BW'(e_stb));
        check("wr_done", BW'(vme_wr_done), BW'(e_wd));
        check("rd_done", BW'(vme_rd_done), BW'(e_rd));
        if (e_rd) check("rd_data", BW'(vme_rd_data), BW'(e_rdat));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;

        for (int a = 0; a < 8; a++) cyc(1'b1, 1'b0, a, '0);

        cyc(1'b0, 1'b1, 4, 32'hDEAD_BEEF);
        idle(2);
        cyc(1'b0, 1'b1, 5, 32'h0123_4567);
        idle(1);
        check("reg2_commit", BW'(regs_o[2*RW +: RW]), BW'(64'hDEAD_BEEF_0123_4567));
        check("reg2_strobe", BW'(wr_strobe_o), BW'(3'b100));
        idle(1);

        cyc(1'b0, 1'b1, 0, 32'hA5A5_A5A5);
        cyc(1'b0, 1'b1, 1, 32'h5A5A_5A5A);
        idle(1);
        check("pulse_show", BW'(regs_o[RW-1:0]),
              ATOM ? BW'(64'hA5A5_A5A5_5A5A_5A5A) : BW'(64'h0000_0000_5A5A_5A5A));
        idle(1);
        check("pulse_clear", BW'(regs_o[RW-1:0]), '0);
        cyc(1'b1, 1'b0, 0, '0);
        check("pulse_read", BW'(vme_rd_data), '0);

        cyc(1'b0, 1'b1, 2, 32'h1111_1111);
        cyc(1'b0, 1'b1, 3, 32'h2222_2222);
        idle(2);
        cyc(1'b1, 1'b0, 2, '0);
        check("snap_ms", BW'(vme_rd_data), BW'(32'h1111_1111));
        cyc(1'b0, 1'b1, 2, 32'h3333_3333);
        cyc(1'b0, 1'b1, 3, 32'h4444_4444);
        idle(2);
        cyc(1'b1, 1'b0, 3, '0);
        check("snap_ls", BW'(vme_rd_data),
              ATOM ? BW'(32'h2222_2222) : BW'(32'h4444_4444));

        cyc(1'b0, 1'b1, 2, 32'h5555_5555);
        cyc(1'b0, 1'b1, 3, 32'h6666_6666);
        cyc(1'b1, 1'b0, 2, '0);
        check("rd_precommit", BW'(vme_rd_data),
              ATOM ? BW'(32'h3333_3333) : BW'(32'h5555_5555));
        idle(2);

        cyc(1'b0, 1'b1, 6, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b1, 7, 32'hFFFF_FFFF);
        check("oor_wdone", BW'(vme_wr_done), BW'(1'b1));
        cyc(1'b1, 1'b0, 7, '0);
        check("oor_rdata", BW'(vme_rd_data), '0);
        idle(1);

        cyc(1'b0, 1'b1, 5, 32'hCAFE_F00D);
        rst_n = 1'b0;
        idle(1);
        check("rst_wdone", BW'(vme_wr_done), '0);
        check("rst_regs", regs_o, '0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), $urandom);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wide_reg_bank.md
# wide_reg_bank

Parametrised bank of wide control registers behind a VME-style single-cycle-strobe bus. Each register is `WORDS`×32 bits. Registers are individually selectable as storage or auto-clearing pulse registers. Multi-word registers are written and read atomically through shadow staging. The block is the generalised successor of the generated single-register slaves and sits between the VME bus interface and the application logic.

## Interface
Parameters:
- `NREGS`, 4, number of wide registers (1..64).
- `WORDS`, 2, 32-bit words per register; power of two, 1..8.
- `PULSE_MASK`, 0, `NREGS` bits; bit i=1 makes register i a pulse register.
- `AW`, derived as $clog2(NREGS*WORDS)+2, byte-address width.

Ports:
- `clk`, in, 1: bus clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `vme_addr`, in, [AW-1:2]: word address; register = addr/WORDS, word offset = addr%WORDS.
- `vme_wr_data`, in, 32: write data.
- `vme_wr_mem`, in, 1: one-cycle write strobe.
- `vme_rd_mem`, in, 1: one-cycle read strobe.
- `vme_rd_data`, out, 32: read data, valid while `vme_rd_done`=1.
- `vme_wr_done`, out, 1: one-cycle write acknowledge.
- `vme_rd_done`, out, 1: one-cycle read acknowledge.
- `regs_o`, out, NREGS*WORDS*32: register values, register i at [(i+1)*WORDS*32-1 : i*WORDS*32].
- `wr_strobe_o`, out, NREGS: one-cycle pulse when register i commits a new value.

## Operation
- Word order is big-endian: offset 0 is the most-significant word and offset WORDS-1 is the least-significant word.
- Write path:
  - The strobe, address and data are registered (pipeline stage 0).
  - The address is decoded, and the selected word is written or staged (stage 1).
  - `vme_wr_done` is driven from the stage-1 acknowledge register.
- Commit: writing offset WORDS-1 transfers the shadow words plus the new LS word into the register. In the same cycle `wr_strobe_o[i]`=1.
- Storage register: holds its value until the next commit.
- Pulse register:
  - Equals the committed value for exactly one cycle after commit, otherwise all zeros.
  - Reads as zero.
- Read path:
  - The address is decoded combinationally from `vme_addr`.
  - Data and done are registered.
  - Reading offset 0 of a storage register snapshots the full register into a read shadow. Offsets 1..WORDS-1 return the read-shadow words.
- Out-of-range address:
  - Read is acknowledged with 0x00000000.
  - Write is acknowledged and ignored.
- Simultaneous read and write are processed independently. A read in the same cycle as a commit returns the pre-commit value.
- Back-to-back strobes are accepted every cycle, and each one is acknowledged in order.
- `WORDS`=1: no shadows; every write commits.
- Reset values:
  - `regs_o` all 0 and all shadows 0.
  - `vme_rd_data` 0.
  - `vme_wr_done`, `vme_rd_done` and `wr_strobe_o` all 0.
- Reset mid-transaction drops in-flight requests; no done is issued for them.

## Timing
- Write latency: `vme_wr_mem` at cycle N gives `regs_o` and `wr_strobe_o` updated at N+2 and `vme_wr_done`=1 at N+2.
- Read latency: `vme_rd_mem` at cycle N gives `vme_rd_done`=1 and `vme_rd_data` valid at N+1.
- Pulse register output is non-zero only in cycle N+2 of the committing write.
- Writes to offsets 0..WORDS-2 only update the shadow. They produce no `regs_o` change and no strobe, but are acknowledged at N+2.

## Configuration
- `WIDE_REG_BANK_ATOMIC_EN` defined: write shadow, commit-on-LS-word and read snapshot are enabled as described.
- `WIDE_REG_BANK_ATOMIC_EN` undefined:
  - Each word write updates its word of the register directly at N+2.
  - `wr_strobe_o[i]` pulses on every word write.
  - Pulse registers show only the written word for one cycle; other words are zero.
  - Reads return live register words; no read shadow is instantiated.

## Structure
- Package `wide_reg_bank_pkg`: word-width constant (32), address-width function, and a word-offset/register-index split function.
- Sub-module `wide_reg_slice`: one register containing write shadow, storage/pulse logic, read shadow and strobe. It is generated `NREGS` times.
- The top level holds the bus pipeline, address decode and read mux.

## Test plan
- Reset, then read all addresses: all `vme_rd_data`=0, each `vme_rd_done` exactly at N+1.
- NREGS=4, WORDS=2: write 0xDEADBEEF at offset 0, then 0x01234567 at offset 1 of reg 2.
  - After the first write, `regs_o` is unchanged.
  - At N+2 of the second write, reg 2 = 0xDEADBEEF_01234567 and `wr_strobe_o`=0100.
- `PULSE_MASK`=0001: committing 0xA5A5A5A5_5A5A5A5A to reg 0 shows the value for exactly one cycle, then zero; a read of reg 0 returns 0.
- Atomic read: read reg 1 offset 0, then commit a new value to reg 1, then read offset 1 → the pre-commit LS word is returned.
- Address beyond NREGS*WORDS: the write is acknowledged with no `regs_o` change, and the read returns 0 with done.
- Assert `rst_n`=0 one cycle after `vme_wr_mem`: no `vme_wr_done` and registers are 0. Repeat the atomic cases with the macro undefined, expecting per-word commits.
